// File: rtl/accel_bus_ctrl_if.sv
// accel_bus_ctrl_if: CPU request/response port and shared accelerator bus of accel_bus_ctrl
interface accel_bus_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int REG_ADDR_W = 3,
  parameter int NUM_ACC = 2,
  parameter int SEL_W = NUM_ACC > 1 ? $clog2(NUM_ACC) : 1
);
  logic req_valid, req_ready;
  logic [1:0] req_op;
  logic [SEL_W-1:0] req_acc;
  logic [REG_ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic rsp_valid, rsp_err;
  logic [DATA_W-1:0] rsp_data;
  logic [NUM_ACC-1:0] acc_en, acc_start, acc_done, acc_busy;
  logic [1:0] bus_rdwr;
  logic [REG_ADDR_W-1:0] bus_regaddr;
  logic [DATA_W-1:0] bus_wdata, bus_rdata;
  logic bus_oe, timeout_flag, flag_clr;
  modport master (
    input req_valid, req_op, req_acc, req_addr, req_wdata, acc_done, bus_rdata, flag_clr,
    output req_ready, rsp_valid, rsp_data, rsp_err, acc_en, acc_start, bus_rdwr,
           bus_regaddr, bus_wdata, bus_oe, acc_busy, timeout_flag
  );
  modport slave (
    output req_valid, req_op, req_acc, req_addr, req_wdata, acc_done, bus_rdata, flag_clr,
    input req_ready, rsp_valid, rsp_data, rsp_err, acc_en, acc_start, bus_rdwr,
          bus_regaddr, bus_wdata, bus_oe, acc_busy, timeout_flag
  );
endinterface

// File: rtl/accel_bus_ctrl.sv
// accel_bus_ctrl: CPU-side master for the multi-channel accelerator register bus
module accel_bus_ctrl #(
  parameter int DATA_W = 16,
  parameter int REG_ADDR_W = 3,
  parameter int NUM_ACC = 2,
  parameter int TIMEOUT = 1023
) (
  input logic clk,
  input logic rst,
  accel_bus_ctrl_if.master io
);
  localparam int SEL_W = NUM_ACC > 1 ? $clog2(NUM_ACC) : 1;
  localparam int NS = 1 << SEL_W;
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, WR, RD, RD_CAP, START, WAIT, RSP} state_t;
  state_t state, state_nxt;
  logic [SEL_W-1:0] sel;
  logic [REG_ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, rdata;
  logic [NUM_ACC-1:0] busy, onehot;
  logic [NS-1:0] busy_x, done_x;
  logic [CW-1:0] cnt;
  logic err, tflag, valid_ch, accept, done_sel, tmo;
  assign busy_x = NS'(busy);
  assign done_x = NS'(io.acc_done);
  assign valid_ch = 32'(io.req_acc) < NUM_ACC;
  assign io.req_ready = !rst && state == IDLE && (io.req_op == 2'b00 || !valid_ch || !busy_x[io.req_acc]);
  assign accept = io.req_valid && io.req_ready;
  assign onehot = NUM_ACC'(1) << sel;
  assign done_sel = done_x[sel];
  assign tmo = state == WAIT && !done_sel && cnt == CW'(TIMEOUT - 1);
  assign io.acc_busy = busy;
  assign io.timeout_flag = tflag;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      sel <= '0;
      addr <= '0;
      wdata <= '0;
      rdata <= '0;
      err <= 1'b0;
      cnt <= '0;
      busy <= '0;
      tflag <= 1'b0;
    end else begin
      if (accept) begin
        sel <= io.req_acc;
        addr <= io.req_addr;
        wdata <= io.req_wdata;
      end
      rdata <= state == RD_CAP ? io.bus_rdata : '0;
      err <= (accept && !valid_ch) || tmo;
      cnt <= state == WAIT ? cnt + 1'b1 : '0;
      busy <= (busy & ~io.acc_done & ~(tmo ? onehot : '0)) | (state == START ? onehot : '0);
      tflag <= tmo || (tflag && !io.flag_clr);
    end
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = !valid_ch ? RSP :
                                    io.req_op == 2'b01 ? WR :
                                    io.req_op == 2'b10 ? RD :
                                    io.req_op == 2'b11 ? START :
                                    (busy_x[io.req_acc] && !done_x[io.req_acc]) ? WAIT : RSP;
      RD: state_nxt = RD_CAP;
      RD_CAP: state_nxt = RSP;
      WAIT: if (done_sel || tmo) state_nxt = RSP;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    io.acc_en = state inside {WR, RD, RD_CAP, START} ? onehot : '0;
    io.acc_start = state == START ? onehot : '0;
    io.bus_rdwr = state == WR ? 2'b01 : state inside {RD, RD_CAP} ? 2'b10 : 2'b00;
    io.bus_regaddr = state inside {WR, RD, RD_CAP} ? addr : '0;
    io.bus_wdata = state == WR ? wdata : '0;
    io.bus_oe = state == WR;
    io.rsp_valid = state == RSP;
    io.rsp_data = state == RSP ? rdata : '0;
    io.rsp_err = state == RSP && err;
  end
endmodule

// File: tb/tb_accel_bus_ctrl.sv
// tb_accel_bus_ctrl: directed and randomized checks of accel_bus_ctrl against a transaction-queue model
module tb_accel_bus_ctrl;
  localparam int NA = 3, DW = 16, AW = 3, TO = 8;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  accel_bus_ctrl_if #(.DATA_W(DW), .REG_ADDR_W(AW), .NUM_ACC(NA)) ifc();
  accel_bus_ctrl #(.DATA_W(DW), .REG_ADDR_W(AW), .NUM_ACC(NA), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .io(ifc)
  );
  typedef struct packed {
    logic rdy, rv;
    logic [DW-1:0] rd;
    logic re;
    logic [NA-1:0] en, st;
    logic [1:0] rw;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    logic oe;
  } slot_t;
  localparam int BW = $bits(slot_t) + NA + 1;
  slot_t q[$];
  slot_t ex;
  logic [NA-1:0] busy_m = '0;
  logic tflag_m = 1'b0;
  bit waiting = 0;
  int wch, wn;
  logic [DW-1:0] mem_m[NA][8];
  logic [DW-1:0] env_mem[NA][8];
  int n_vec = 0, n_err = 0;
  // accelerator side: registered read data, writes land at the end of the write cycle
  function automatic int ch_of(logic [NA-1:0] e);
    return e[2] ? 2 : e[1] ? 1 : 0;
  endfunction
  always @(posedge clk) begin
    if (ifc.bus_rdwr == 2'b10) ifc.bus_rdata <= env_mem[ch_of(ifc.acc_en)][ifc.bus_regaddr];
    if (ifc.bus_rdwr == 2'b01) env_mem[ch_of(ifc.acc_en)][ifc.bus_regaddr] <= ifc.bus_wdata;
  end
  function automatic slot_t rsp(bit e, logic [DW-1:0] d);
    slot_t s = '0;
    s.rv = 1'b1;
    s.re = e;
    s.rd = d;
    return s;
  endfunction
  function automatic slot_t drv(int a, logic [1:0] rw, logic [AW-1:0] ad, logic [DW-1:0] wd);
    slot_t s = '0;
    s.en = NA'(1) << a;
    s.rw = rw;
    s.ad = ad;
    s.wd = wd;
    s.oe = rw == 2'b01;
    return s;
  endfunction
  function automatic logic [BW-1:0] obs();
    return {ifc.req_ready, ifc.rsp_valid, ifc.rsp_data, ifc.rsp_err, ifc.acc_en, ifc.acc_start,
            ifc.bus_rdwr, ifc.bus_regaddr, ifc.bus_wdata, ifc.bus_oe, ifc.acc_busy, ifc.timeout_flag};
  endfunction
  task automatic apply(input bit v, input bit [1:0] op, a, input bit [AW-1:0] ad,
                       input bit [DW-1:0] wd, input bit [NA-1:0] dn, input bit clr, r);
    ifc.req_valid = v;
    ifc.req_op = op;
    ifc.req_acc = a;
    ifc.req_addr = ad;
    ifc.req_wdata = wd;
    ifc.acc_done = dn;
    ifc.flag_clr = clr;
    rst = r;
    #1;
    if (q.size() > 0) ex = q[0];
    else begin
      ex = '0;
      ex.rdy = !r && !waiting && (op == 2'b00 || (a >= NA ? 1'b1 : !busy_m[a]));
    end
  endtask
  task automatic nop(input bit [NA-1:0] dn, input bit clr);
    apply(0, 0, 0, 0, 0, dn, clr, 0);
  endtask
  task automatic adv();
    slot_t s, rs;
    logic [NA-1:0] nb;
    int a;
    bit tmo;
    @(posedge clk);
    if (rst) begin
      q.delete();
      busy_m = '0;
      tflag_m = 1'b0;
      waiting = 0;
    end else begin
      s = '0;
      if (q.size() > 0) s = q.pop_front();
      a = int'(ifc.req_acc);
      tmo = 0;
      nb = busy_m & ~ifc.acc_done;
      if (waiting) begin
        if (ifc.acc_done[wch]) begin q.push_back(rsp(0, '0)); waiting = 0; end
        else if (wn == TO - 1) begin tmo = 1; nb[wch] = 1'b0; q.push_back(rsp(1, '0)); waiting = 0; end
        else wn++;
      end
      nb |= s.st;
      tflag_m = tmo || (tflag_m && !ifc.flag_clr);
      if (ifc.req_valid && ex.rdy) begin
        if (a >= NA) q.push_back(rsp(1, '0));
        else case (ifc.req_op)
          2'b00: if (busy_m[a] && !ifc.acc_done[a]) begin waiting = 1; wch = a; wn = 0; end
                 else q.push_back(rsp(0, '0));
          2'b01: begin
            q.push_back(drv(a, 2'b01, ifc.req_addr, ifc.req_wdata));
            mem_m[a][ifc.req_addr] = ifc.req_wdata;
          end
          2'b10: begin
            rs = drv(a, 2'b10, ifc.req_addr, '0);
            q.push_back(rs);
            q.push_back(rs);
            q.push_back(rsp(0, mem_m[a][ifc.req_addr]));
          end
          default: begin
            rs = '0;
            rs.en = NA'(1) << a;
            rs.st = NA'(1) << a;
            q.push_back(rs);
          end
        endcase
      end
      busy_m = nb;
    end
    @(negedge clk);
  endtask
  task automatic test_reset();
    apply(0, 0, 0, 0, 0, 0, 0, 1); adv();
    apply(1, 2'b11, 0, 0, 0, 0, 0, 1);
    n_vec++;
    if (obs() !== '0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", obs()); end
    adv();
    nop(0, 0);
    n_vec++;
    if ({ifc.acc_en, ifc.bus_rdwr, ifc.bus_oe, ifc.rsp_valid, ifc.acc_busy, ifc.timeout_flag, ifc.req_ready} !== {3'b0, 2'b0, 1'b0, 1'b0, 3'b0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL reset_idle: got %h", obs());
    end
    adv();
  endtask
  task automatic test_write();
    apply(1, 2'b01, 1, 5, 16'hBEEF, 0, 0, 0);
    n_vec++;
    if (ifc.req_ready !== 1'b1) begin n_err++; $display("FAIL write_ready: got %b want 1", ifc.req_ready); end
    adv();
    nop(0, 0);
    n_vec++;
    if ({ifc.acc_en, ifc.bus_rdwr, ifc.bus_regaddr, ifc.bus_wdata, ifc.bus_oe, ifc.rsp_valid, ifc.req_ready} !== {3'b010, 2'b01, 3'd5, 16'hBEEF, 1'b1, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL write_bus: got %h", obs());
    end
    adv();
    nop(0, 0);
    n_vec++;
    if ({ifc.acc_en, ifc.bus_oe, ifc.rsp_valid, ifc.req_ready} !== {3'b000, 1'b0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL write_end: got %h", obs());
    end
    adv();
  endtask
  task automatic test_read();
    logic [24:0] want;
    apply(1, 2'b01, 0, 2, 16'h1234, 0, 0, 0); adv();
    nop(0, 0); adv();
    apply(1, 2'b10, 0, 2, 0, 0, 0, 0);
    n_vec++;
    if (ifc.req_ready !== 1'b1) begin n_err++; $display("FAIL read_ready: got %b want 1", ifc.req_ready); end
    adv();
    for (int k = 1; k <= 3; k++) begin
      nop(0, 0);
      want = k == 3 ? {1'b1, 16'h1234, 1'b0, 3'b000, 2'b00, 2'b0} : {1'b0, 16'h0, 1'b0, 3'b001, 2'b10, 2'd2};
      n_vec++;
      if ({ifc.rsp_valid, ifc.rsp_data, ifc.rsp_err, ifc.acc_en, ifc.bus_rdwr, ifc.bus_regaddr[1:0]} !== want) begin
        n_err++; $display("FAIL read_cycle%0d: got %h want %h", k, {ifc.rsp_valid, ifc.rsp_data, ifc.rsp_err, ifc.acc_en, ifc.bus_rdwr, ifc.bus_regaddr[1:0]}, want);
      end
      adv();
    end
  endtask
  task automatic test_busy_stall();
    apply(1, 2'b11, 0, 0, 0, 0, 0, 0); adv();
    nop(0, 0);
    n_vec++;
    if ({ifc.acc_start, ifc.acc_en} !== {3'b001, 3'b001}) begin
      n_err++; $display("FAIL start_pulse: got %b/%b want 001/001", ifc.acc_start, ifc.acc_en);
    end
    adv();
    for (int k = 0; k < 10; k++) begin
      apply(1, 2'b10, 0, 2, 0, k == 9 ? 3'b001 : 3'b000, 0, 0);
      n_vec++;
      if ({ifc.req_ready, ifc.acc_busy[0]} !== 2'b01) begin
        n_err++; $display("FAIL stall_%0d: ready/busy got %b%b want 01", k, ifc.req_ready, ifc.acc_busy[0]);
      end
      adv();
    end
    apply(1, 2'b10, 0, 2, 0, 0, 0, 0);
    n_vec++;
    if ({ifc.req_ready, ifc.acc_busy[0]} !== 2'b10) begin
      n_err++; $display("FAIL stall_release: ready/busy got %b%b want 10", ifc.req_ready, ifc.acc_busy[0]);
    end
    adv();
    nop(0, 0); adv();
    nop(0, 0); adv();
    nop(0, 0);
    n_vec++;
    if ({ifc.rsp_valid, ifc.rsp_data} !== {1'b1, 16'h1234}) begin
      n_err++; $display("FAIL stall_read: got %b %h want 1 1234", ifc.rsp_valid, ifc.rsp_data);
    end
    adv();
  endtask
  task automatic test_wait_done();
    apply(1, 2'b11, 1, 0, 0, 0, 0, 0); adv();
    nop(0, 0); adv();
    apply(1, 2'b11, 0, 0, 0, 0, 0, 0); adv();
    nop(0, 0); adv();
    apply(1, 2'b00, 1, 0, 0, 0, 0, 0);
    n_vec++;
    if (ifc.req_ready !== 1'b1) begin n_err++; $display("FAIL wait_ready: got %b want 1", ifc.req_ready); end
    adv();
    for (int k = 1; k <= 7; k++) begin
      nop(k == 7 ? 3'b010 : 3'b000, 0);
      n_vec++;
      if ({ifc.rsp_valid, ifc.req_ready, ifc.acc_busy} !== {1'b0, 1'b0, 3'b011}) begin
        n_err++; $display("FAIL wait_hold%0d: got %b%b%b want 00011", k, ifc.rsp_valid, ifc.req_ready, ifc.acc_busy);
      end
      adv();
    end
    nop(0, 0);
    n_vec++;
    if ({ifc.rsp_valid, ifc.rsp_err, ifc.rsp_data, ifc.acc_busy} !== {1'b1, 1'b0, 16'h0, 3'b001}) begin
      n_err++; $display("FAIL wait_rsp: got %b %b %h %b want 1 0 0000 001", ifc.rsp_valid, ifc.rsp_err, ifc.rsp_data, ifc.acc_busy);
    end
    adv();
    nop(3'b001, 0); adv();
    nop(0, 0);
    n_vec++;
    if (ifc.acc_busy !== 3'b000) begin n_err++; $display("FAIL wait_clear: busy got %b want 000", ifc.acc_busy); end
    adv();
  endtask
  task automatic test_timeout();
    apply(1, 2'b11, 0, 0, 0, 0, 0, 0); adv();
    nop(0, 0); adv();
    apply(1, 2'b00, 0, 0, 0, 0, 0, 0); adv();
    for (int k = 1; k <= TO; k++) begin
      nop(0, 0);
      n_vec++;
      if ({ifc.rsp_valid, ifc.acc_busy[0], ifc.timeout_flag} !== 3'b010) begin
        n_err++; $display("FAIL tmo_wait%0d: got %b%b%b want 010", k, ifc.rsp_valid, ifc.acc_busy[0], ifc.timeout_flag);
      end
      adv();
    end
    nop(0, 0);
    n_vec++;
    if ({ifc.rsp_valid, ifc.rsp_err, ifc.rsp_data, ifc.acc_busy, ifc.timeout_flag} !== {1'b1, 1'b1, 16'h0, 3'b000, 1'b1}) begin
      n_err++; $display("FAIL tmo_rsp: got %b %b %h %b %b want 1 1 0000 000 1", ifc.rsp_valid, ifc.rsp_err, ifc.rsp_data, ifc.acc_busy, ifc.timeout_flag);
    end
    adv();
    for (int k = 0; k < 3; k++) begin
      nop(0, 0);
      n_vec++;
      if (ifc.timeout_flag !== 1'b1) begin n_err++; $display("FAIL tmo_sticky%0d: got %b want 1", k, ifc.timeout_flag); end
      adv();
    end
    nop(0, 1); adv();
    nop(0, 0);
    n_vec++;
    if (ifc.timeout_flag !== 1'b0) begin n_err++; $display("FAIL tmo_clear: got %b want 0", ifc.timeout_flag); end
    adv();
  endtask
  task automatic test_invalid();
    apply(1, 2'b10, 3, 4, 0, 0, 0, 0);
    n_vec++;
    if (ifc.req_ready !== 1'b1) begin n_err++; $display("FAIL inv_ready: got %b want 1", ifc.req_ready); end
    adv();
    nop(0, 0);
    n_vec++;
    if ({ifc.rsp_valid, ifc.rsp_err, ifc.rsp_data, ifc.acc_en, ifc.bus_rdwr, ifc.bus_oe} !== {1'b1, 1'b1, 16'h0, 3'b0, 2'b0, 1'b0}) begin
      n_err++; $display("FAIL inv_rsp: got %h", obs());
    end
    adv();
    nop(0, 0);
    n_vec++;
    if ({ifc.rsp_valid, ifc.acc_en} !== 4'b0) begin n_err++; $display("FAIL inv_after: got %h", obs()); end
    adv();
  endtask
  task automatic test_reset_mid();
    apply(1, 2'b10, 1, 5, 0, 0, 0, 0); adv();
    apply(0, 0, 0, 0, 0, 0, 0, 1);
    n_vec++;
    if ({ifc.acc_en, ifc.bus_rdwr, ifc.req_ready} !== {3'b010, 2'b10, 1'b0}) begin
      n_err++; $display("FAIL rstmid_pre: got %h", obs());
    end
    adv();
    for (int k = 0; k < 4; k++) begin
      nop(0, 0);
      n_vec++;
      if ({ifc.acc_en, ifc.bus_rdwr, ifc.bus_regaddr, ifc.bus_oe, ifc.rsp_valid, ifc.rsp_data} !== '0) begin
        n_err++; $display("FAIL rstmid_%0d: got %h", k, obs());
      end
      adv();
    end
  endtask
  task automatic test_random(input int n);
    logic [NA-1:0] dn;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < NA; c++) dn[c] = $urandom_range(0, 7) == 0;
      apply($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            AW'($urandom), DW'($urandom), dn, $urandom_range(0, 15) == 0, $urandom_range(0, 249) == 0);
      n_vec++;
      if (obs() !== {ex, busy_m, tflag_m}) begin
        n_err++; $display("FAIL random_%0d: dut %h model %h", i, obs(), {ex, busy_m, tflag_m});
      end
      adv();
    end
  endtask
  initial begin
    for (int c = 0; c < NA; c++)
      for (int a = 0; a < 8; a++) begin
        mem_m[c][a] = DW'($urandom);
        env_mem[c][a] <= mem_m[c][a];
      end
    test_reset();
    test_write();
    test_read();
    test_busy_stall();
    test_wait_done();
    test_timeout();
    test_invalid();
    test_reset_mid();
    test_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
